cmd_stream_arbiter: RTL and testbench

CMD_STREAM_ARBITER -- requirements
Module: cmd_stream_arbiter

---
 rtl/cmd_arb_pkg.sv | 22 ++
 rtl/cmd_fifo.sv | 80 ++++++++
 rtl/cmd_stream_arbiter.sv | 137 +++++++++++++
 tb/tb_cmd_stream_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_arb_pkg.sv
// Shared types and width helpers for the command-stream arbiter.
// The arbiter state enum and the minimum-one clog2 used for id widths.
package cmd_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // A single channel still needs a one-bit id field.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous per-channel FIFO with wrap-bit pointers and a registered
// not-full ready, so upstream never sees a combinational path from the sink.
module cmd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    input  logic                     rd_pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    rptr_r;
    logic [PW-1:0]    wptr_nxt_s;
    logic [PW-1:0]    rptr_nxt_s;
    logic             wr_ready_r;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_nxt_s;

    assign empty_s  = (wptr_r == rptr_r);
    assign push_s   = wr_valid & wr_ready_r;
    assign pop_s    = rd_pop & ~empty_s;
    assign wr_ready = wr_ready_r;
    assign empty    = empty_s;
    assign level    = wptr_r - rptr_r;
    assign rd_data  = mem_r[rptr_r[AW-1:0]];

    // Next pointer values; ready is derived from these so it tracks the post-edge fill.
    always_comb begin
        wptr_nxt_s = wptr_r;
        rptr_nxt_s = rptr_r;
        if (push_s) begin
            wptr_nxt_s = wptr_r + PTR_ONE;
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (pop_s) begin
            rptr_nxt_s = rptr_r + PTR_ONE;
        end else begin
            rptr_nxt_s = rptr_r;
        end
    end

    assign full_nxt_s = (wptr_nxt_s[AW] != rptr_nxt_s[AW]) &&
                        (wptr_nxt_s[AW-1:0] == rptr_nxt_s[AW-1:0]);

    // Pointer and registered-ready state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r     <= {PW{1'b0}};
            rptr_r     <= {PW{1'b0}};
            wr_ready_r <= 1'b0;
        end else begin
            wptr_r     <= wptr_nxt_s;
            rptr_r     <= rptr_nxt_s;
            wr_ready_r <= ~full_nxt_s;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/cmd_stream_arbiter.sv
// Merges NUM_CH AXI-stream command channels into one stream, granting
// round-robin per command and holding the grant until the tlast beat.
module cmd_stream_arbiter
    import cmd_arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                      clk,
    input  logic                                      reset_n_i,
    input  logic [NUM_CH-1:0]                         s_axis_tvalid_i,
    output logic [NUM_CH-1:0]                         s_axis_tready_o,
    input  logic [NUM_CH*DATA_W-1:0]                  s_axis_tdata_i,
    input  logic [NUM_CH-1:0]                         s_axis_tlast_i,
    output logic                                      m_axis_tvalid_o,
    input  logic                                      m_axis_tready_i,
    output logic [DATA_W-1:0]                         m_axis_tdata_o,
    output logic                                      m_axis_tlast_o,
    output logic [clog2_min1(NUM_CH)-1:0]             m_axis_tid_o,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]  level_o
);

    localparam int TID_W = clog2_min1(NUM_CH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_e         state_r;
    arb_state_e         state_nxt_s;
    logic [TID_W-1:0]   grant_r;
    logic [TID_W-1:0]   grant_nxt_s;
    logic [TID_W-1:0]   last_grant_r;
    logic [TID_W-1:0]   last_grant_nxt_s;
    logic [TID_W-1:0]   scan_pick_s;
    logic [TID_W-1:0]   scan_idx_s;
    logic               scan_found_s;
    logic [NUM_CH-1:0]  fifo_empty_s;
    logic [NUM_CH-1:0]  pop_s;
    logic [DATA_W:0]    head_s [NUM_CH];
    logic [DATA_W:0]    grant_head_s;
    logic               grant_empty_s;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        cmd_fifo #(
            .WIDTH (DATA_W + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (reset_n_i),
            .wr_valid (s_axis_tvalid_i[k]),
            .wr_data  ({s_axis_tlast_i[k], s_axis_tdata_i[k*DATA_W +: DATA_W]}),
            .wr_ready (s_axis_tready_o[k]),
            .rd_pop   (pop_s[k]),
            .rd_data  (head_s[k]),
            .empty    (fifo_empty_s[k]),
            .level    (level_o[k*LVL_W +: LVL_W])
        );
    end

    assign grant_head_s  = head_s[grant_r];
    assign grant_empty_s = fifo_empty_s[grant_r];
    assign m_axis_tid_o  = grant_r;

    // Round-robin scan starting just after the channel that finished last.
    always_comb begin
        scan_found_s = 1'b0;
        scan_pick_s  = last_grant_r;
        scan_idx_s   = last_grant_r;
        for (int i = 1; i <= NUM_CH; i++) begin
            scan_idx_s = TID_W'((int'(last_grant_r) + i) % NUM_CH);
            if (!scan_found_s && !fifo_empty_s[scan_idx_s]) begin
                scan_found_s = 1'b1;
                scan_pick_s  = scan_idx_s;
            end else begin
                scan_found_s = scan_found_s;
            end
        end
    end

    // Next-state, pop and merged-output decode.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        pop_s            = {NUM_CH{1'b0}};
        m_axis_tvalid_o  = 1'b0;
        m_axis_tdata_o   = {DATA_W{1'b0}};
        m_axis_tlast_o   = 1'b0;
        case (state_r)
            IDLE: begin
                if (scan_found_s) begin
                    grant_nxt_s = scan_pick_s;
                    state_nxt_s = BURST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                // An empty granted FIFO simply stalls; the grant is never abandoned mid-command.
                if (!grant_empty_s) begin
                    m_axis_tvalid_o = 1'b1;
                    m_axis_tdata_o  = grant_head_s[DATA_W-1:0];
                    m_axis_tlast_o  = grant_head_s[DATA_W];
                    if (m_axis_tready_i) begin
                        pop_s[grant_r] = 1'b1;
                        if (grant_head_s[DATA_W]) begin
                            last_grant_nxt_s = grant_r;
                            state_nxt_s      = IDLE;
                        end else begin
                            state_nxt_s = BURST;
                        end
                    end else begin
                        state_nxt_s = BURST;
                    end
                end else begin
                    state_nxt_s = BURST;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Arbiter state, current grant and last completed grant.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            grant_r      <= {TID_W{1'b0}};
            last_grant_r <= TID_W'(NUM_CH - 1);
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Directed self-checking bench for cmd_stream_arbiter (4 channels, depth-4 FIFOs).
module tb_cmd_stream_arbiter;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int TID_W      = 2;
    localparam int LVL_W      = 3;
    localparam int BP_WORDS   = 60;

    logic                      clk = 1'b0;
    logic                      reset_n_i = 1'b1;
    logic [NUM_CH-1:0]         s_valid = '0;
    logic [NUM_CH-1:0]         s_ready;
    logic [NUM_CH*DATA_W-1:0]  s_data = '0;
    logic [NUM_CH-1:0]         s_last = '0;
    logic                      m_valid;
    logic                      m_ready = 1'b1;
    logic [DATA_W-1:0]         m_data;
    logic                      m_last;
    logic [TID_W-1:0]          m_tid;
    logic [NUM_CH*LVL_W-1:0]   level;

    int pass_cnt = 0;
    int check_cnt = 0;
    int cyc = 0;
    int stab_err = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [TID_W-1:0]  tid;
        int                edge_n;
    } beat_t;
    beat_t beats[$];

    logic              pv = 1'b0;
    logic [DATA_W-1:0] pd = '0;
    logic              pl = 1'b0;
    logic [TID_W-1:0]  pt = '0;

    cmd_stream_arbiter #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n_i       (reset_n_i),
        .s_axis_tvalid_i (s_valid),
        .s_axis_tready_o (s_ready),
        .s_axis_tdata_i  (s_data),
        .s_axis_tlast_i  (s_last),
        .m_axis_tvalid_o (m_valid),
        .m_axis_tready_i (m_ready),
        .m_axis_tdata_o  (m_data),
        .m_axis_tlast_o  (m_last),
        .m_axis_tid_o    (m_tid),
        .level_o         (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every beat that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (reset_n_i && m_valid && m_ready)
            beats.push_back('{m_data, m_last, m_tid, cyc + 1});
    end

    // Output must hold while valid and not ready.
    always @(negedge clk) begin
        if (!reset_n_i) begin
            pv <= 1'b0;
        end else begin
            if (pv && (!m_valid || m_data !== pd || m_last !== pl || m_tid !== pt))
                stab_err <= stab_err + 1;
            pv <= m_valid && !m_ready;
            pd <= m_data;
            pl <= m_last;
            pt <= m_tid;
        end
    end

    task automatic wait_for_beats(input int n, input int budget);
        int k;
        k = 0;
        while (beats.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic test_reset();
        #2 reset_n_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cnt++;
        if (s_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", s_ready); else pass_cnt++;
        check_cnt++;
        if (m_valid !== 1'b0 || m_last !== 1'b0) $display("FAIL reset_valid_last: got %b %b want 0 0", m_valid, m_last); else pass_cnt++;
        check_cnt++;
        if (m_data !== 16'h0000 || m_tid !== 2'd0) $display("FAIL reset_data_tid: got %h %0d want 0 0", m_data, m_tid); else pass_cnt++;
        check_cnt++;
        if (level !== 12'h000) $display("FAIL reset_level: got %h want 000", level); else pass_cnt++;
        @(negedge clk);
        reset_n_i = 1'b1;
        #1;
        check_cnt++;
        if (s_ready !== 4'b0000) $display("FAIL release_ready_pre_edge: got %b want 0000", s_ready); else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++;
        if (s_ready !== 4'b1111) $display("FAIL release_ready: got %b want 1111", s_ready); else pass_cnt++;
    endtask

    task automatic test_two_ch();
        logic [DATA_W-1:0] exp_d [4];
        logic              exp_l [4];
        logic [TID_W-1:0]  exp_t [4];
        int n0;
        exp_d = '{16'h0A01, 16'h0A02, 16'h0B01, 16'h0B02};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_t = '{2'd0, 2'd0, 2'd1, 2'd1};
        m_ready = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            beats.delete();
            s_valid = 4'b0011; s_last = 4'b0000;
            s_data[15:0] = 16'h0A01; s_data[31:16] = 16'h0B01;
            @(posedge clk); #1;
            n0 = cyc;
            s_data[15:0] = 16'h0A02; s_data[31:16] = 16'h0B02; s_last = 4'b0011;
            @(posedge clk); #1;
            s_valid = 4'b0000; s_last = 4'b0000;
            wait_for_beats(4, 30);
            check_cnt++;
            if (beats.size() != 4) begin
                $display("FAIL two_ch_count rep%0d: got %0d beats want 4", rep, beats.size());
            end else begin
                pass_cnt++;
                for (int i = 0; i < 4; i++) begin
                    check_cnt++;
                    if (beats[i].data !== exp_d[i] || beats[i].last !== exp_l[i] || beats[i].tid !== exp_t[i])
                        $display("FAIL two_ch_beat rep%0d #%0d: got d=%h l=%b t=%0d want d=%h l=%b t=%0d",
                                 rep, i, beats[i].data, beats[i].last, beats[i].tid, exp_d[i], exp_l[i], exp_t[i]);
                    else pass_cnt++;
                end
                check_cnt++;
                if (beats[0].edge_n != n0 + 2 || beats[2].edge_n != n0 + 5)
                    $display("FAIL two_ch_timing rep%0d: got edges %0d,%0d want %0d,%0d",
                             rep, beats[0].edge_n, beats[2].edge_n, n0 + 2, n0 + 5);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_single();
        int n0;
        beats.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 4'b0001;
            s_data[15:0] = DATA_W'(16'hA001 + i);
            s_last = (i == 2) ? 4'b0001 : 4'b0000;
            @(posedge clk); #1;
            if (i == 0) n0 = cyc;
        end
        s_valid = 4'b0000; s_last = 4'b0000;
        wait_for_beats(3, 20);
        check_cnt++;
        if (beats.size() != 3) begin
            $display("FAIL single_count: got %0d beats want 3", beats.size());
        end else begin
            pass_cnt++;
            for (int i = 0; i < 3; i++) begin
                check_cnt++;
                if (beats[i].data !== DATA_W'(16'hA001 + i) || beats[i].last !== (i == 2) ||
                    beats[i].tid !== 2'd0 || beats[i].edge_n != n0 + 2 + i)
                    $display("FAIL single_beat #%0d: got d=%h l=%b t=%0d edge=%0d want d=%h l=%0d t=0 edge=%0d",
                             i, beats[i].data, beats[i].last, beats[i].tid, beats[i].edge_n,
                             16'hA001 + i, (i == 2), n0 + 2 + i);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (m_valid !== 1'b0 || level !== 12'h000) $display("FAIL single_idle: got valid=%b level=%h want 0 000", m_valid, level); else pass_cnt++;
    endtask

    task automatic test_full();
        int idx, k, s0;
        logic acc;
        beats.delete();
        s0 = stab_err;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 4'b0001; s_last = 4'b0000;
            s_data[15:0] = DATA_W'(16'h1000 + i);
            @(posedge clk); #1;
            if (i == 2) begin
                check_cnt++;
                if (s_ready[0] !== 1'b1) $display("FAIL full_ready_at3: got %b want 1", s_ready[0]); else pass_cnt++;
            end
        end
        check_cnt++;
        if (s_ready[0] !== 1'b0) $display("FAIL full_ready_at4: got %b want 0", s_ready[0]); else pass_cnt++;
        s_data[15:0] = 16'h1004;
        repeat (2) begin @(posedge clk); #1; end
        check_cnt++;
        if (level[2:0] !== 3'd4) $display("FAIL full_level: got %0d want 4", level[2:0]); else pass_cnt++;
        m_ready = 1'b1;
        #1;
        check_cnt++;
        if (s_ready[0] !== 1'b0) $display("FAIL full_no_comb_ready: got %b want 0", s_ready[0]); else pass_cnt++;
        idx = 4; k = 0;
        while (idx < 6 && k < 20) begin
            s_valid[0] = 1'b1;
            s_data[15:0] = DATA_W'(16'h1000 + idx);
            s_last[0] = (idx == 5);
            acc = s_ready[0];
            @(posedge clk); #1;
            k++;
            if (acc) idx++;
        end
        s_valid = 4'b0000; s_last = 4'b0000;
        wait_for_beats(6, 30);
        check_cnt++;
        if (beats.size() != 6) begin
            $display("FAIL full_count: got %0d beats want 6", beats.size());
        end else begin
            pass_cnt++;
            for (int i = 0; i < 6; i++) begin
                check_cnt++;
                if (beats[i].data !== DATA_W'(16'h1000 + i) || beats[i].last !== (i == 5))
                    $display("FAIL full_beat #%0d: got d=%h l=%b want d=%h l=%0d",
                             i, beats[i].data, beats[i].last, 16'h1000 + i, (i == 5));
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (level !== 12'h000 || stab_err != s0) $display("FAIL full_drain: got level=%h stab=%0d want 000 %0d", level, stab_err, s0); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] exp_d [4];
        logic [TID_W-1:0]  exp_t [4];
        int n0;
        exp_d = '{16'hC101, 16'hC102, 16'hD001, 16'hD002};
        exp_t = '{2'd1, 2'd1, 2'd0, 2'd0};
        beats.delete();
        m_ready = 1'b1;
        s_valid = 4'b0011; s_last = 4'b0000;
        s_data[15:0] = 16'hD001; s_data[31:16] = 16'hC101;
        @(posedge clk); #1;
        n0 = cyc;
        s_valid = 4'b0001; s_last = 4'b0001; s_data[15:0] = 16'hD002;
        @(posedge clk); #1;
        s_valid = 4'b0000; s_last = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_cnt++;
            if (m_valid !== 1'b0 || m_tid !== 2'd1)
                $display("FAIL stall_hold edge%0d: got valid=%b tid=%0d want 0 1", n0 + 2 + i, m_valid, m_tid);
            else pass_cnt++;
        end
        s_valid = 4'b0010; s_last = 4'b0010; s_data[31:16] = 16'hC102;
        @(posedge clk); #1;
        s_valid = 4'b0000; s_last = 4'b0000;
        wait_for_beats(4, 30);
        check_cnt++;
        if (beats.size() != 4) begin
            $display("FAIL stall_count: got %0d beats want 4", beats.size());
        end else begin
            pass_cnt++;
            for (int i = 0; i < 4; i++) begin
                check_cnt++;
                if (beats[i].data !== exp_d[i] || beats[i].tid !== exp_t[i])
                    $display("FAIL stall_beat #%0d: got d=%h t=%0d want d=%h t=%0d",
                             i, beats[i].data, beats[i].tid, exp_d[i], exp_t[i]);
                else pass_cnt++;
            end
            check_cnt++;
            if (beats[1].edge_n != n0 + 7 || beats[2].edge_n != n0 + 9)
                $display("FAIL stall_timing: got edges %0d,%0d want %0d,%0d",
                         beats[1].edge_n, beats[2].edge_n, n0 + 7, n0 + 9);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int sent [NUM_CH];
        int exp_n [NUM_CH];
        int order_err, atom_err, k, s0, t;
        logic [NUM_CH-1:0] acc;
        logic [TID_W-1:0]  cur_t;
        logic              in_cmd;
        beats.delete();
        s0 = stab_err;
        for (int c = 0; c < NUM_CH; c++) begin sent[c] = 0; exp_n[c] = 0; end
        k = 0;
        while (beats.size() < NUM_CH * BP_WORDS && k < 4000) begin
            for (int c = 0; c < NUM_CH; c++) begin
                s_valid[c] = (sent[c] < BP_WORDS);
                s_data[c*DATA_W +: DATA_W] = DATA_W'(c * 4096 + sent[c]);
                s_last[c] = (sent[c] % 3 == 2);
            end
            m_ready = ($urandom_range(0, 2) != 0);
            acc = s_valid & s_ready;
            @(posedge clk); #1;
            k++;
            for (int c = 0; c < NUM_CH; c++) if (acc[c]) sent[c]++;
        end
        s_valid = 4'b0000; s_last = 4'b0000; m_ready = 1'b1;
        order_err = 0; atom_err = 0; in_cmd = 1'b0; cur_t = '0;
        foreach (beats[i]) begin
            t = int'(beats[i].tid);
            if (in_cmd && beats[i].tid !== cur_t) atom_err++;
            if (beats[i].data !== DATA_W'(t * 4096 + exp_n[t])) order_err++;
            if (beats[i].last !== (exp_n[t] % 3 == 2)) order_err++;
            exp_n[t]++;
            in_cmd = !beats[i].last;
            cur_t = beats[i].tid;
        end
        check_cnt++;
        if (beats.size() != NUM_CH * BP_WORDS) $display("FAIL bp_count: got %0d want %0d", beats.size(), NUM_CH * BP_WORDS); else pass_cnt++;
        check_cnt++;
        if (order_err != 0) $display("FAIL bp_order: got %0d errors want 0", order_err); else pass_cnt++;
        check_cnt++;
        if (atom_err != 0) $display("FAIL bp_atomic: got %0d interleaves want 0", atom_err); else pass_cnt++;
        check_cnt++;
        if (stab_err != s0) $display("FAIL bp_stable: got %0d violations want 0", stab_err - s0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        beats.delete();
        m_ready = 1'b0;
        s_valid = 4'b1100; s_last = 4'b0000;
        s_data[47:32] = 16'hE201; s_data[63:48] = 16'hE301;
        @(posedge clk); #1;
        s_valid = 4'b0100; s_data[47:32] = 16'hE202;
        @(posedge clk); #1;
        s_valid = 4'b0000;
        @(posedge clk); #1;
        check_cnt++;
        if (m_valid !== 1'b1) $display("FAIL mid_burst_active: got valid=%b want 1", m_valid); else pass_cnt++;
        #2 reset_n_i = 1'b0;
        #1;
        check_cnt++;
        if (m_valid !== 1'b0 || level !== 12'h000) $display("FAIL mid_reset_async: got valid=%b level=%h want 0 000", m_valid, level); else pass_cnt++;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check_cnt++;
        if (beats.size() != 0 || m_valid !== 1'b0) $display("FAIL mid_reset_quiet: got beats=%0d valid=%b want 0 0", beats.size(), m_valid); else pass_cnt++;
        s_valid = 4'b0011; s_last = 4'b0011;
        s_data[15:0] = 16'hF001; s_data[31:16] = 16'hF101;
        @(posedge clk); #1;
        s_valid = 4'b0000; s_last = 4'b0000;
        wait_for_beats(2, 20);
        check_cnt++;
        if (beats.size() != 2) begin
            $display("FAIL mid_reset_count: got %0d beats want 2", beats.size());
        end else if (beats[0].tid !== 2'd0 || beats[0].data !== 16'hF001 || beats[1].tid !== 2'd1 || beats[1].data !== 16'hF101) begin
            $display("FAIL mid_reset_first_grant: got t=%0d d=%h then t=%0d d=%h want t=0 d=f001 then t=1 d=f101",
                     beats[0].tid, beats[0].data, beats[1].tid, beats[1].data);
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_two_ch();
        test_single();
        test_full();
        test_stall();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
